// File: rtl/seq_gen_pkg.sv
// Shared state encodings and default parameters for the seq_gen serial transmitter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int DEF_PAT_W      = 8;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left-shift register; msb exposes the next bit to transmit.
module seq_gen_shreg #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] load_val,
    input  logic             shift_en,
    output logic             msb
);

    logic [PAT_W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift_en)
            q <= q << 1;
    end

    assign msb = q[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: MSB-first frame, optional even-parity bit, zero gap.
// Parity bit is enabled by defining SEQ_GEN_PARITY_EN.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W      = DEF_PAT_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    logic [LEN_W-1:0] bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [LEN_W-1:0] len_c;
    logic [PAT_W-1:0] aligned;
    logic             accept;
    logic             sr_shift;
    logic             sr_msb;
`ifdef SEQ_GEN_PARITY_EN
    logic             par;
`endif

    // Left-justify the pattern so bit [len-1] lands in the MSB.
    always_comb begin
        len_c   = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
        aligned = pattern << (LEN_W'(PAT_W) - len_c);
    end

    assign accept   = (state == ST_IDLE) && start && (len != '0);
    assign sr_shift = (state == ST_SHIFT) && (bit_cnt != '0);

    // First bit goes straight to ser_out, so the register holds the remainder.
    seq_gen_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (aligned << 1),
        .shift_en (sr_shift),
        .msb      (sr_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
`ifdef SEQ_GEN_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SHIFT;
                        ser_out   <= aligned[PAT_W-1];
                        ser_valid <= 1'b1;
                        ready     <= 1'b0;
                        bit_cnt   <= len_c - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
                        par       <= aligned[PAT_W-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt != '0) begin
                        ser_out <= sr_msb;
                        bit_cnt <= bit_cnt - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
                        par     <= par ^ sr_msb;
`endif
                    end else begin
`ifdef SEQ_GEN_PARITY_EN
                        state   <= ST_PARITY;
                        ser_out <= par;
`else
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                            ready <= 1'b1;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                        end
`endif
                    end
                end
                ST_PARITY: begin
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: frame table plus hand sequences for len=0,
// back-to-back frames and asynchronous reset mid-frame.
module tb_seq_gen;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int GAP   = 2;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             ready, ser_out, ser_valid, done;

    int vecs = 0;
    int errs = 0;

    seq_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .ready     (ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        int         nb;
        logic [7:0] bits;
        logic       par;
    } vec_t;

    vec_t tbl [8];

    // Compares {ready, done, ser_valid, ser_out}.
    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {ready, done, ser_valid, ser_out};
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got {rdy,done,vld,out}=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    // Checks every cycle from the first bit through the done cycle.
    task automatic check_frame(input string tag, input logic [7:0] bits, input int nb,
                               input logic par, input bit drop_start, input bit glitch);
        logic [3:0] exp;
        for (int c = 1; c <= nb + PB + GAP + 1; c++) begin
            @(negedge clk);
            if (drop_start) start = 1'b0;
            if (glitch && c == 1) pattern = 8'h00;
            if (glitch && c == 2) pattern = 8'h03;
            if (c <= nb)           exp = {3'b001, bits[nb-c]};
            else if (c <= nb + PB) exp = {3'b001, par};
            else if (c <= nb + PB + GAP) exp = 4'b0000;
            else                   exp = 4'b1100;
            check($sformatf("%s c%0d", tag, c), exp);
        end
    endtask

    initial begin
        tbl[0] = '{8'h09, 4'd4,  4, 8'b0000_1001, 1'b0};
        tbl[1] = '{8'hA5, 4'd12, 8, 8'b1010_0101, 1'b0};
        tbl[2] = '{8'h07, 4'd3,  3, 8'b0000_0111, 1'b1};
        tbl[3] = '{8'h03, 4'd2,  2, 8'b0000_0011, 1'b0};
        tbl[4] = '{8'h80, 4'd8,  8, 8'b1000_0000, 1'b1};
        tbl[5] = '{8'h01, 4'd1,  1, 8'b0000_0001, 1'b1};
        tbl[6] = '{8'hFF, 4'd8,  8, 8'b1111_1111, 1'b0};
        tbl[7] = '{8'h3C, 4'd5,  5, 8'b0001_1100, 1'b1};

        rst = 1'b1; start = 1'b0; pattern = '0; len = '0;
        repeat (2) @(negedge clk);
        check("reset", 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", 4'b1000);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b1; pattern = tbl[i].pat; len = tbl[i].len;
            check_frame($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].nb, tbl[i].par, 1'b1, 1'b0);
        end

        // len=0 is ignored
        @(negedge clk);
        start = 1'b1; pattern = 8'hFF; len = 4'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("len0 c%0d", c), 4'b1000);
        end

        // held start: second frame accepted on the done cycle; mid-frame pattern change ignored
        @(negedge clk);
        start = 1'b1; pattern = 8'h03; len = 4'd2;
        check_frame("b2b f1", 8'h03, 2, 1'b0, 1'b0, 1'b1);
        check_frame("b2b f2", 8'h03, 2, 1'b0, 1'b1, 1'b0);

        // async reset after two of four bits
        @(negedge clk);
        start = 1'b1; pattern = 8'h09; len = 4'd4;
        @(negedge clk);
        start = 1'b0;
        check("rst pre b1", 4'b0011);
        @(negedge clk);
        check("rst pre b2", 4'b0010);
        #2 rst = 1'b1;
        #1 check("async rst", 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        check("post rst idle", 4'b1000);
        @(negedge clk);
        start = 1'b1; pattern = 8'h09; len = 4'd4;
        check_frame("post rst", 8'h09, 4, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        check("final idle", 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial pattern transmitter; drives the single-bit line consumed by the serial sequence detector FSM (the detector's `in` input).
- Accepts a parallel pattern and bit length through a start/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, then holds an idle gap of zeros.
- Used standalone to generate detector stimulus and as the transmit end of the serial link.

Parameters:
- PAT_W, 8, maximum pattern width in bits.
- LEN_W, 4, width of the length field; must hold PAT_W.
- GAP_CYCLES, 2, number of forced-zero idle cycles after each frame (0 allowed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to send; accepted only while ready=1.
- pattern  in  PAT_W  bits to send; bit [len-1] goes out first.
- len  in  LEN_W  number of bits to send, 1..PAT_W.
- ready  out  1  high in IDLE; module can accept start.
- ser_out  out  1  serial data line (registered).
- ser_valid  out  1  high while ser_out carries a frame bit (data or parity).
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, immediate, including mid-frame): state=IDLE, ser_out=0, ser_valid=0, done=0, ready=1, shift register and counters cleared.
- States: IDLE, SHIFT, PARITY (feature only), GAP; 2-bit encoding.
- IDLE:
  - ready=1.
  - On an edge with start=1 and 1<=len<=PAT_W, capture pattern and len.
  - Load ser_out=pattern[len-1] and ser_valid=1 on that same edge, go to SHIFT with bit counter=len-1.
  - The first bit is visible the cycle after start is sampled: latency 1.
- len handling:
  - len=0: start is ignored; stay IDLE, no done.
  - len>PAT_W: clamped to PAT_W.
- SHIFT:
  - ready=0.
  - Each edge with counter>0 drives the next lower bit and decrements the counter.
  - At counter=0 the last bit is on the line; the next edge goes to PARITY (feature on), else to GAP.
- GAP:
  - ser_out=0, ser_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES=0: the last-bit edge goes directly to IDLE.
- done:
  - Asserted for one cycle, coincident with the first IDLE cycle after a frame.
  - A start sampled in that same cycle is accepted; back-to-back frames are allowed.
- Occupancy: frame = len (+1 with parity) + GAP_CYCLES cycles from first bit to done.
- Ignored while ready=0: start, pattern and len; the captured values are used.
- Outside SHIFT/PARITY: ser_out is always 0, so the line idles low and a downstream detector sees zeros.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined:
  - After the last data bit, one PARITY cycle drives ser_out = XOR of the len transmitted bits (even parity), with ser_valid=1.
  - Then GAP; frame length is len+1.
- Undefined:
  - The PARITY state and XOR accumulator are absent; SHIFT goes directly to GAP.
  - State encoding is unchanged.

Decomposition:
- Package seq_gen_pkg:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2, ST_GAP=2'd3.
  - default PAT_W/GAP_CYCLES constants.
- One sub-module, seq_gen_shreg:
  - PAT_W-wide loadable left-shift register with load, shift enable and serial MSB output.
  - The top holds the FSM, bit and gap counters, and parity.

Test Plan:
- Reset, then pattern=8'h09, len=4, start for 1 cycle: ser_out=1,0,0,1 on cycles 1-4 with ser_valid=1; 0,0 on cycles 5-6 with ser_valid=0; done=1 on cycle 7; ready=1 from cycle 7.
- pattern=8'hFF, len=0, start: ready stays 1, ser_valid never asserts, no done. Then len=12 with pattern=8'hA5: 8 bits 1,0,1,0,0,1,0,1 are sent (clamped).
- Back-to-back frames: hold start=1 with pattern=8'h03, len=2: frames "11",gap,"11" with no extra idle cycle. Toggling pattern to 8'h00 mid-frame does not alter bits in flight.
- Async rst asserted mid-SHIFT (after 2 of 4 bits): ser_out/ser_valid drop to 0 without waiting for a clock edge; ready=1; the next start sends a clean full frame.
- Loopback into the sequence detector: pattern 4'b1001 then 2'b11. The detector out must pulse after each frame's final bit, and zero-gaps must return it to IDLE.
- With SEQ_GEN_PARITY_EN, pattern=8'h07, len=3: bits 1,1,1, then parity 1, then gap; done on cycle 7 with GAP_CYCLES=2. With 8'h03, len=2, the parity bit is 0.
